// File: rtl/alu_disp_pkg.sv
// alu_disp_pkg
//   Shared definitions for the ALU result display path:
//   - active-low segment codes, bit order {G,F,E,D,C,B,A};
//   - 5-bit symbol codes consumed by seg7_encode;
//   - disp_word_t, the captured ALU result (tens, units, zero, error);
//   - digit_symbol(), which maps a result word and a digit position to a symbol.
package alu_disp_pkg;

    localparam int NUM_DIGITS = 4;

    // Segment patterns, active-low {G,F,E,D,C,B,A}
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_R     = 7'h2F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_DIGITS [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    // Symbol codes: 0..9 are the decimal digits themselves
    localparam logic [4:0] SYM_E     = 5'd10;
    localparam logic [4:0] SYM_R     = 5'd11;
    localparam logic [4:0] SYM_DASH  = 5'd12;
    localparam logic [4:0] SYM_BLANK = 5'd13;

    typedef struct packed {
        logic [3:0] dec;
        logic [3:0] unis;
        logic       zero;
        logic       error;
    } disp_word_t;

    // A BCD nibble outside 0..9 is shown as a dash
    function automatic logic [4:0] bcd_symbol(input logic [3:0] d);
        return (d > 4'd9) ? SYM_DASH : {1'b0, d};
    endfunction

    // Position 0 is the rightmost digit
    function automatic logic [4:0] digit_symbol(input disp_word_t w, input logic [1:0] idx);
        logic [4:0] sym;
        sym = SYM_BLANK;
        if (w.error) begin
            case (idx)
                2'd0:    sym = SYM_R;
                2'd1:    sym = SYM_R;
                2'd2:    sym = SYM_E;
                default: sym = SYM_BLANK;
            endcase
        end else begin
            case (idx)
                2'd0:    sym = bcd_symbol(w.unis);
                2'd1:    sym = (w.dec == 4'd0) ? SYM_BLANK : bcd_symbol(w.dec);
                default: sym = SYM_BLANK;
            endcase
        end
        return sym;
    endfunction

endpackage

// File: rtl/seg7_encode.sv
// seg7_encode
//   Combinational symbol-to-segment decoder for a common-anode display.
//   Ports:
//     sym  in  5  symbol code (0..9 digit, SYM_E, SYM_R, SYM_DASH, SYM_BLANK)
//     seg  out 7  {G,F,E,D,C,B,A}, active-low; unknown codes render blank
module seg7_encode
    import alu_disp_pkg::*;
(
    input  logic [4:0] sym,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (sym <= 5'd9) begin
            seg = SEG_DIGITS[sym[3:0]];
        end else begin
            case (sym)
                SYM_E:    seg = SEG_E;
                SYM_R:    seg = SEG_R;
                SYM_DASH: seg = SEG_DASH;
                default:  seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/alu_display_scanner.sv
// alu_display_scanner
//   Multiplexed 4-digit 7-segment scanner for the ALU result. The result is
//   captured into a pending register on 'load' and moved into the displayed
//   shadow only on the frame wrap (last tick of digit 3), so a frame is never
//   drawn from two different results.
//   Parameters:
//     REFRESH_CNT  mclk cycles each digit stays lit (>= 2)
//     BLINK_DIV    frames per blink half-period (only with ERR_BLINK_EN)
//   Ports:
//     mclk         in   1  clock
//     rst          in   1  synchronous reset, active-high
//     load         in   1  capture strobe for dec_bin/unis_bin/zero/error
//     dec_bin      in   4  tens digit, BCD
//     unis_bin     in   4  units digit, BCD
//     zero         in   1  ALU zero flag
//     error        in   1  ALU error flag
//     ready        out  1  high when no capture is waiting for the wrap
//     select_disp  out  4  anodes, active-low, bit0 = rightmost digit
//     seg          out  7  {G,F,E,D,C,B,A}, active-low
//     zero_led     out  1  zero flag of the displayed result
//   Build option:
//     ERR_BLINK_EN  when defined, an error result blinks: all anodes are
//                   turned off for BLINK_DIV frames, on for BLINK_DIV frames.
module alu_display_scanner
    import alu_disp_pkg::*;
#(
    parameter int REFRESH_CNT = 50000,
    parameter int BLINK_DIV   = 32
) (
    input  logic       mclk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] dec_bin,
    input  logic [3:0] unis_bin,
    input  logic       zero,
    input  logic       error,
    output logic       ready,
    output logic [3:0] select_disp,
    output logic [6:0] seg,
    output logic       zero_led
);

    localparam int              TICK_W    = $clog2(REFRESH_CNT);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(REFRESH_CNT - 1);

    logic [TICK_W-1:0] tick_cnt_reg;
    logic [1:0]        dig_idx_reg;
    logic              pend_flag_reg;
    disp_word_t        pend_word_reg;
    disp_word_t        shadow_reg;
    logic [3:0]        select_disp_reg;
    logic [6:0]        seg_reg;

    disp_word_t        in_word;
    logic              tick_end;
    logic              frame_end;
    logic              blank_all;
    logic [3:0]        anode_onehot;
    logic [6:0]        digit_seg [NUM_DIGITS];

    assign in_word   = '{dec: dec_bin, unis: unis_bin, zero: zero, error: error};
    assign tick_end  = (tick_cnt_reg == TICK_LAST);
    assign frame_end = tick_end && (dig_idx_reg == 2'd3);

    // One decoder per digit position, all fed from the shadow; the scan
    // index only picks which one reaches the output register.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            logic [4:0] sym;
            assign sym = digit_symbol(shadow_reg, 2'(gi));
            seg7_encode u_enc (
                .sym (sym),
                .seg (digit_seg[gi])
            );
        end
    endgenerate

    assign anode_onehot = 4'b0001 << dig_idx_reg;

    always_ff @(posedge mclk) begin
        if (rst) begin
            tick_cnt_reg    <= '0;
            dig_idx_reg     <= 2'd0;
            pend_flag_reg   <= 1'b0;
            pend_word_reg   <= '0;
            shadow_reg      <= '0;
            select_disp_reg <= 4'b1111;
            seg_reg         <= SEG_BLANK;
        end else begin
            tick_cnt_reg <= tick_end ? '0 : tick_cnt_reg + TICK_W'(1);
            if (tick_end) begin
                dig_idx_reg <= dig_idx_reg + 2'd1;
            end

            // A load on the wrap edge bypasses the pending register so the
            // new result appears in the very frame that starts now.
            if (frame_end) begin
                if (load) begin
                    shadow_reg <= in_word;
                end else if (pend_flag_reg) begin
                    shadow_reg <= pend_word_reg;
                end
                pend_flag_reg <= 1'b0;
            end else if (load) begin
                pend_word_reg <= in_word;
                pend_flag_reg <= 1'b1;
            end

            select_disp_reg <= blank_all ? 4'b1111 : ~anode_onehot;
            seg_reg         <= digit_seg[dig_idx_reg];
        end
    end

`ifdef ERR_BLINK_EN
    localparam int FRAME_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_DIV - 1);

    logic [FRAME_W-1:0] frame_cnt_reg;
    logic               blink_on_reg;

    always_ff @(posedge mclk) begin
        if (rst) begin
            frame_cnt_reg <= '0;
            blink_on_reg  <= 1'b1;
        end else if (frame_end) begin
            if (frame_cnt_reg == FRAME_LAST) begin
                frame_cnt_reg <= '0;
                blink_on_reg  <= ~blink_on_reg;
            end else begin
                frame_cnt_reg <= frame_cnt_reg + FRAME_W'(1);
            end
        end
    end

    assign blank_all = shadow_reg.error && !blink_on_reg;
`else
    logic unused_blink_div;
    assign unused_blink_div = (BLINK_DIV > 0);
    assign blank_all        = 1'b0;
`endif

    assign ready       = ~pend_flag_reg;
    assign select_disp = select_disp_reg;
    assign seg         = seg_reg;
    assign zero_led    = shadow_reg.zero;

endmodule
